fwd_hazard_ctrl: RTL and testbench

//  Parametrised forwarding and hazard controller for the ARM pipeline. Generalises the EXE operand

---
 rtl/fwd_hazard_ctrl_if.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the ID/EXE pipeline control and the forwarding/hazard controller.
// The master side drives the pipeline state. The slave side returns the operand selects and the stall.
interface fwd_hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 2
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                       enable_forwarding;
  logic                       flush;
  logic                       exe_valid;
  logic [REG_W-1:0]           exe_dest;
  logic                       exe_wb_en;
  logic                       exe_mem_read;
  logic [NUM_SRC*REG_W-1:0]   exe_src;
  logic [NUM_SRC-1:0]         exe_src_valid;
  logic [NUM_SRC*REG_W-1:0]   id_src;
  logic [NUM_SRC-1:0]         id_src_valid;
  logic [NUM_SRC*SEL_W-1:0]   sel_src;
  logic                       hazard_stall;

  modport master (
    output enable_forwarding, flush, exe_valid, exe_dest, exe_wb_en, exe_mem_read,
           exe_src, exe_src_valid, id_src, id_src_valid,
    input  sel_src, hazard_stall
  );

  modport slave (
    input  enable_forwarding, flush, exe_valid, exe_dest, exe_wb_en, exe_mem_read,
           exe_src, exe_src_valid, id_src, id_src_valid,
    output sel_src, hazard_stall
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selector and hazard controller. It keeps a registered destination-tag history of the
// post-EXE stages and runs a load-use stall FSM. It also has a stall-on-pending-write mode for use without forwarding.
module fwd_hazard_ctrl #(
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } tag_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  tag_t                     tag_q [1:DEPTH];
  tag_t                     tag_d [1:DEPTH];
  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     load_hit, pend_hit, stall;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     mem_read_unused;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tag_d[1].valid    = bus.exe_valid;
    tag_d[1].dest     = bus.exe_dest;
    tag_d[1].wb_en    = bus.exe_wb_en;
    tag_d[1].mem_read = bus.exe_mem_read;
    for (int k = 2; k <= DEPTH; k++) tag_d[k] = tag_q[k-1];
    if (bus.flush) begin
      for (int k = 1; k <= DEPTH; k++) tag_d[k].valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) tag_q[k] <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) tag_q[k] <= tag_d[k];
    end
  end

  // Scan from oldest to youngest so that the youngest matching stage overwrites the select.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (bus.enable_forwarding && bus.exe_src_valid[i] && tag_q[k].valid && tag_q[k].wb_en &&
            tag_q[k].dest == bus.exe_src[i*REG_W +: REG_W])
          sel[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  // The WB stage writes in the first half-cycle, so tag[DEPTH] never causes a hazard.
  always_comb begin
    load_hit = 1'b0;
    pend_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_valid[i]) begin
        if (bus.exe_valid && bus.exe_wb_en && bus.exe_dest == bus.id_src[i*REG_W +: REG_W]) begin
          pend_hit = 1'b1;
          if (bus.exe_mem_read) load_hit = 1'b1;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (tag_q[k].valid && tag_q[k].wb_en && tag_q[k].dest == bus.id_src[i*REG_W +: REG_W])
            pend_hit = 1'b1;
        end
      end
    end
  end

  // The load flag is kept in the history for debug visibility only.
  always_comb begin
    mem_read_unused = 1'b0;
    for (int k = 1; k <= DEPTH; k++) mem_read_unused = mem_read_unused | tag_q[k].mem_read;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle that detects the load is the first stall cycle; HOLD covers the remaining LOAD_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable_forwarding || bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (load_hit && LOAD_LAT > 1) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
        HOLD: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (rst_n && !bus.flush) begin
      if (bus.enable_forwarding) stall = (state_q == HOLD) || load_hit;
      else                       stall = pend_hit;
    end
  end

  assign bus.sel_src      = sel;
  assign bus.hazard_stall = stall;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl. The same inputs drive two instances, one with LOAD_LAT=2 and one with
// LOAD_LAT=3, and each vector lists the expected selects and the expected stall of each instance.
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.NUM_SRC(2), .REG_W(4), .DEPTH(2)) bus_a ();
  fwd_hazard_ctrl_if #(.NUM_SRC(2), .REG_W(4), .DEPTH(2)) bus_b ();

  fwd_hazard_ctrl #(.NUM_SRC(2), .REG_W(4), .DEPTH(2), .LOAD_LAT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  fwd_hazard_ctrl #(.NUM_SRC(2), .REG_W(4), .DEPTH(2), .LOAD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic       en, fl, ev;
    logic [3:0] ed;
    logic       ew, em;
    logic [7:0] xs;   // {exe_src1, exe_src0}
    logic [1:0] xv;
    logic [7:0] is;   // {id_src1, id_src0}
    logic [1:0] iv;
    logic [3:0] sel;  // {sel1, sel0}
    logic       sa, sb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic fl, logic ev, logic [3:0] ed, logic ew, logic em,
                              logic [3:0] xs1, logic [3:0] xs0, logic [1:0] xv,
                              logic [3:0] is1, logic [3:0] is0, logic [1:0] iv,
                              logic [1:0] sel1, logic [1:0] sel0, logic sa, logic sb);
    vec_t v;
    v.en = en; v.fl = fl; v.ev = ev; v.ed = ed; v.ew = ew; v.em = em;
    v.xs = {xs1, xs0}; v.xv = xv; v.is = {is1, is0}; v.iv = iv;
    v.sel = {sel1, sel0}; v.sa = sa; v.sb = sb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus_a.enable_forwarding = v.en; bus_b.enable_forwarding = v.en;
    bus_a.flush = v.fl;             bus_b.flush = v.fl;
    bus_a.exe_valid = v.ev;         bus_b.exe_valid = v.ev;
    bus_a.exe_dest = v.ed;          bus_b.exe_dest = v.ed;
    bus_a.exe_wb_en = v.ew;         bus_b.exe_wb_en = v.ew;
    bus_a.exe_mem_read = v.em;      bus_b.exe_mem_read = v.em;
    bus_a.exe_src = v.xs;           bus_b.exe_src = v.xs;
    bus_a.exe_src_valid = v.xv;     bus_b.exe_src_valid = v.xv;
    bus_a.id_src = v.is;            bus_b.id_src = v.is;
    bus_a.id_src_valid = v.iv;      bus_b.id_src_valid = v.iv;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sel, input logic sa, input logic sb);
    check({tag, " sel_a"},   32'(bus_a.sel_src),      32'(sel));
    check({tag, " sel_b"},   32'(bus_b.sel_src),      32'(sel));
    check({tag, " stall_a"}, 32'(bus_a.hazard_stall), 32'(sa));
    check({tag, " stall_b"}, 32'(bus_b.hazard_stall), 32'(sb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //              en fl ev ed ew em  xs1 xs0 xv     is1 is0 iv     s1 s0 sa sb
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 0 idle
    vecs.push_back(mk(1, 0, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 1 w r3
    vecs.push_back(mk(1, 0, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 2 w r3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 3, 2'b11, 0, 0, 2'b00, 1, 1, 0, 0)); // 3 youngest wins
    vecs.push_back(mk(1, 0, 1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 4 w r5
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 5 bubble
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 5, 2'b10, 0, 0, 2'b00, 2, 0, 0, 0)); // 6 WB fwd, port0 off
    vecs.push_back(mk(1, 0, 1, 6, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 7 r6 no wb
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 8 bubble
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 6, 6, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0)); // 9 wb_en=0 -> 0
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 10 w r1
    vecs.push_back(mk(1, 0, 1, 2, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 11 w r2
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, 2'b11, 0, 2, 2'b01, 2, 1, 0, 0)); // 12 mixed stages
    vecs.push_back(mk(1, 0, 1, 4, 1, 1, 0, 0, 2'b00, 0, 4, 2'b01, 0, 0, 1, 1)); // 13 load-use
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4, 2'b01, 0, 0, 1, 1)); // 14 hold
    vecs.push_back(mk(1, 0, 1, 9, 1, 0, 0, 4, 2'b01, 0, 0, 2'b00, 0, 2, 0, 1)); // 15 consumer
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 16 released
    vecs.push_back(mk(1, 0, 1, 4, 0, 1, 0, 0, 2'b00, 4, 0, 2'b10, 0, 0, 0, 0)); // 17 load no wb
    vecs.push_back(mk(0, 0, 1, 7, 1, 0, 0, 7, 2'b01, 7, 0, 2'b10, 0, 0, 1, 1)); // 18 no-fwd EXE
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 2'b01, 7, 0, 2'b10, 0, 0, 1, 1)); // 19 no-fwd MEM
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 2'b01, 7, 0, 2'b10, 0, 0, 0, 0)); // 20 in WB: clear
    vecs.push_back(mk(0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 8, 8, 2'b11, 0, 0, 1, 1)); // 21 both ports
    vecs.push_back(mk(0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 8, 8, 2'b11, 0, 0, 1, 1)); // 22 two writers
    vecs.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 2'b00, 0, 3, 2'b01, 0, 0, 0, 0)); // 23 no wb -> 0
    vecs.push_back(mk(1, 0, 1, 2, 1, 1, 0, 0, 2'b00, 0, 2, 2'b01, 0, 0, 1, 1)); // 24 load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 25 fwd off aborts
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 26 stays IDLE
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 27 idle
    vecs.push_back(mk(1, 0, 1, 4, 1, 1, 0, 0, 2'b00, 0, 4, 2'b01, 0, 0, 1, 1)); // 28 load-use
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4, 2'b01, 0, 0, 0, 0)); // 29 flush
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0)); // 30 tags gone
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0)); // 31 idle

    drive(vecs[0]);
    #1;
    check_all("reset", 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      #1 check_all($sformatf("v%0d", i), vecs[i].sel, vecs[i].sa, vecs[i].sb);
    end

    // Asynchronous reset taken while the LOAD_LAT=3 instance is holding.
    @(posedge clk);
    #1 drive(mk(1, 0, 1, 4, 1, 1, 0, 0, 2'b00, 0, 4, 2'b01, 0, 0, 0, 0));
    #1 check_all("rst_load", 4'd0, 1'b1, 1'b1);
    @(posedge clk);
    v = mk(1, 0, 0, 0, 0, 0, 0, 4, 2'b01, 0, 4, 2'b01, 0, 0, 0, 0);
    #1 drive(v);
    #1 check_all("rst_hold", 4'd1, 1'b1, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all("rst_async", 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 drive(v);
    #1 check_all("rst_after", 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
